ipml_prefetch_fifo_v2_0: RTL and testbench

Single-clock first-word-fall-through (FWFT) FIFO, the successor to the v1.5 prefetch FIFO.
- Storage: a 1-cycle-latency simple-dual-port RAM array plus a parametrised prefetch output buffer, presented as valid/ready streams on both sides.
- New over v1.5: selectable prefetch depth, combined fill level, programmable almost-full/almost-empty thresholds, synchronous flush, and sticky overflow/underflow flags.
- Placement: between packet producers and consumers inside one clock domain, wherever a zero-wait-state read port is needed.

---
 rtl/ipml_prefetch_fifo_v2_0.sv | 146 ++++++++++++++
 tb/tb_ipml_prefetch_fifo_v2_0.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipml_prefetch_fifo_v2_0.sv
// FWFT FIFO: registered-read RAM feeding an in-order prefetch buffer whose head drives rd_data.
// Write-to-read latency 2 cycles; wr_ready is registered from the RAM count, rd_valid from the buffer count.
module ipml_prefetch_fifo_v2_0 #(
  parameter int c_DATA_WIDTH  = 32,
  parameter int c_DEPTH_WIDTH = 9,
  parameter int c_PF_DEPTH    = 2,
  parameter int c_AF_LEVEL    = 2**c_DEPTH_WIDTH - 4,
  parameter int c_AE_LEVEL    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [c_DATA_WIDTH-1:0]   wr_data,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  output logic [c_DATA_WIDTH-1:0]   rd_data,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [c_DEPTH_WIDTH:0]    level,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int DEPTH = 2**c_DEPTH_WIDTH;
  localparam int LW    = c_DEPTH_WIDTH + 1;
  localparam int PCW   = $clog2(c_PF_DEPTH + 1);

  localparam logic [LW-1:0]  RAM_WORDS = LW'(DEPTH);
  localparam logic [LW-1:0]  AF_L      = LW'(c_AF_LEVEL);
  localparam logic [LW-1:0]  AE_L      = LW'(c_AE_LEVEL);
  localparam logic [PCW:0]   PF_L      = (PCW+1)'(c_PF_DEPTH);

  logic [c_DATA_WIDTH-1:0]  mem [DEPTH];
  logic [c_DATA_WIDTH-1:0]  ram_q;
  logic [c_DATA_WIDTH-1:0]  pf_data [c_PF_DEPTH];

  logic [c_DEPTH_WIDTH-1:0] wr_ptr;
  logic [c_DEPTH_WIDTH-1:0] rd_ptr;
  logic [LW-1:0]            ram_count;
  logic [LW-1:0]            ram_count_nxt;
  logic [LW-1:0]            level_nxt;
  logic [PCW-1:0]           pf_count;
  logic [PCW-1:0]           land_idx;
  logic [PCW:0]             pf_after;
  logic                     inflight;
  logic                     push;
  logic                     pop;
  logic                     issue;
  logic                     land;

  assign rd_valid = (pf_count != '0);
  assign rd_data  = pf_data[0];

  always_comb begin
    push          = wr_valid & wr_ready & ~flush;
    pop           = rd_valid & rd_ready & ~flush;
    land          = inflight & ~flush;
    // Buffer occupancy once this cycle's landing and pop settle; a read is issued only if it will fit.
    pf_after      = {1'b0, pf_count} + {{PCW{1'b0}}, inflight} - {{PCW{1'b0}}, pop};
    issue         = ~flush & (ram_count != '0) & (pf_after < PF_L);
    land_idx      = pf_count - {{(PCW-1){1'b0}}, pop};
    ram_count_nxt = ram_count + {{(LW-1){1'b0}}, push} - {{(LW-1){1'b0}}, issue};
    level_nxt     = level + {{(LW-1){1'b0}}, push} - {{(LW-1){1'b0}}, pop};
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
    if (issue) begin
      ram_q <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      ram_count    <= '0;
      inflight     <= 1'b0;
      pf_count     <= '0;
      wr_ready     <= 1'b0;
      level        <= '0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      for (int i = 0; i < c_PF_DEPTH; i++) begin
        pf_data[i] <= '0;
      end
    end else if (flush) begin
      // Clearing inflight drops whatever the RAM returns next cycle.
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      ram_count    <= '0;
      inflight     <= 1'b0;
      pf_count     <= '0;
      wr_ready     <= 1'b1;
      level        <= '0;
      almost_full  <= (AF_L == '0);
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      for (int i = 0; i < c_PF_DEPTH; i++) begin
        pf_data[i] <= '0;
      end
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (issue) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      ram_count    <= ram_count_nxt;
      wr_ready     <= (ram_count_nxt < RAM_WORDS);
      inflight     <= issue;
      pf_count     <= pf_count + {{(PCW-1){1'b0}}, land} - {{(PCW-1){1'b0}}, pop};
      level        <= level_nxt;
      almost_full  <= (level_nxt >= AF_L);
      almost_empty <= (level_nxt <= AE_L);
      if (wr_valid && !wr_ready) begin
        overflow <= 1'b1;
      end
      if (rd_ready && !rd_valid) begin
        underflow <= 1'b1;
      end
      if (pop) begin
        for (int i = 0; i < c_PF_DEPTH - 1; i++) begin
          pf_data[i] <= pf_data[i+1];
        end
        pf_data[c_PF_DEPTH-1] <= '0;
      end
      // Landing goes behind the surviving entries; it overrides the shift for that slot.
      if (land) begin
        for (int i = 0; i < c_PF_DEPTH; i++) begin
          if (PCW'(i) == land_idx) begin
            pf_data[i] <= ram_q;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ipml_prefetch_fifo_v2_0.sv
// Directed + random bench for ipml_prefetch_fifo_v2_0 against a queue-based reference model.
module tb_ipml_prefetch_fifo_v2_0;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [4:0] level;
  logic       almost_full;
  logic       almost_empty;
  logic       overflow;
  logic       underflow;

  ipml_prefetch_fifo_v2_0 #(
    .c_DATA_WIDTH (8),
    .c_DEPTH_WIDTH(4),
    .c_PF_DEPTH   (2),
    .c_AF_LEVEL   (16),
    .c_AE_LEVEL   (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .level       (level),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  int         n_push = 0;
  int         n_pop = 0;
  logic [7:0] q[$];
  bit         m_ovf = 0;
  bit         m_udf = 0;
  bit         last_push;
  bit         last_pop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    chk("level", 32'(level), 32'(q.size()));
    chk("almost_full", 32'(almost_full), 32'(q.size() >= 16));
    chk("almost_empty", 32'(almost_empty), 32'(q.size() <= 2));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_udf));
    if (q.size() == 0) chk("rd_valid_when_empty", 32'(rd_valid), 0);
  endtask

  // Sample handshakes mid-cycle, update the model, then step past the next rising edge.
  task automatic tick();
    @(negedge clk);
    last_push = wr_valid & wr_ready;
    last_pop  = rd_valid & rd_ready;
    if (flush) begin
      q.delete();
      m_ovf = 0;
      m_udf = 0;
      last_push = 0;
      last_pop  = 0;
    end else begin
      if (wr_valid && !wr_ready) m_ovf = 1;
      if (rd_ready && !rd_valid) m_udf = 1;
      if (last_pop) begin
        if (q.size() == 0) chk("pop_when_model_empty", 32'(rd_valid), 0);
        else begin
          chk("rd_data_order", 32'(rd_data), 32'(q[0]));
          void'(q.pop_front());
          n_pop++;
        end
      end
      if (last_push) begin
        q.push_back(wr_data);
        n_push++;
      end
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wr_ready"}, 32'(wr_ready), 0);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 0);
    chk({tag, "_level"}, 32'(level), 0);
    chk({tag, "_af"}, 32'(almost_full), 0);
    chk({tag, "_ae"}, 32'(almost_empty), 1);
    chk({tag, "_ovf"}, 32'(overflow), 0);
    chk({tag, "_udf"}, 32'(underflow), 0);
    chk({tag, "_rd_data"}, 32'(rd_data), 0);
  endtask

  initial begin
    int         base;
    int         warm;
    int         nxt;
    bit         tog;
    rst_n = 0; flush = 0; wr_data = 0; wr_valid = 0; rd_ready = 0;

    // Reset values, then wr_ready rises on the first edge after release
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1;
    tick();
    chk("wr_ready_after_release", 32'(wr_ready), 1);

    // Latency: one write, visible after two edges
    wr_valid = 1; wr_data = 8'hA5;
    tick();
    wr_valid = 0;
    chk("lat_rd_valid_e0", 32'(rd_valid), 0);
    tick();
    chk("lat_rd_valid_e1", 32'(rd_valid), 0);
    tick();
    chk("lat_rd_valid_e2", 32'(rd_valid), 1);
    chk("lat_rd_data_e2", 32'(rd_data), 32'h A5);
    chk("lat_level", 32'(level), 1);
    chk("lat_ae", 32'(almost_empty), 1);
    rd_ready = 1;
    tick();
    rd_ready = 0;

    // Fill: hold wr_valid, data advances only on acceptance
    base = n_push;
    nxt = 0;
    for (int c = 0; c < 25; c++) begin
      wr_valid = 1;
      wr_data = 8'(nxt);
      tick();
      if (last_push) nxt++;
    end
    wr_valid = 0;
    chk("fill_accepted", 32'(n_push - base), 18);
    chk("fill_wr_ready", 32'(wr_ready), 0);
    chk("fill_level", 32'(level), 18);
    chk("fill_af", 32'(almost_full), 1);
    chk("fill_overflow", 32'(overflow), 1);
    chk("fill_rd_data", 32'(rd_data), 0);

    // Drain with alternating rd_ready; never pop while empty
    base = n_pop;
    tog = 1;
    for (int c = 0; c < 100 && (n_pop - base) < 18; c++) begin
      rd_ready = tog & rd_valid;
      tog = ~tog;
      tick();
    end
    rd_ready = 0;
    chk("drain_count", 32'(n_pop - base), 18);
    chk("drain_level", 32'(level), 0);
    chk("drain_rd_valid", 32'(rd_valid), 0);
    chk("drain_underflow", 32'(underflow), 0);
    chk("drain_wr_ready", 32'(wr_ready), 1);

    // Streaming at one word per cycle in both directions
    base = n_pop;
    warm = 0;
    for (int c = 0; c < 100; c++) begin
      wr_valid = 1;
      wr_data = 8'($urandom_range(0, 255));
      tick();
      if (c == 10) warm = q.size();
      if (c > 10) chk("stream_level_const", 32'(level), 32'(warm));
      rd_ready = rd_valid;
    end
    wr_valid = 0;
    for (int c = 0; c < 40 && q.size() > 0; c++) begin
      rd_ready = rd_valid;
      tick();
    end
    rd_ready = 0;
    chk("stream_pops", 32'(n_pop - base), 100);
    chk("stream_level_end", 32'(level), 0);

    // Pop on empty sets the sticky underflow without changing the level
    rd_ready = 1;
    tick();
    rd_ready = 0;
    tick();
    chk("udf_sticky", 32'(underflow), 1);

    // Flush with a RAM read in flight and a write and pop presented
    for (int c = 0; c < 10; c++) begin
      wr_valid = 1;
      wr_data = 8'(8'h40 + c);
      tick();
    end
    wr_valid = 0;
    repeat (3) tick();
    rd_ready = 1;
    tick();
    flush = 1; wr_valid = 1; wr_data = 8'hEE; rd_ready = 1;
    tick();
    flush = 0; wr_valid = 0; rd_ready = 0;
    chk("flush_level", 32'(level), 0);
    chk("flush_rd_valid", 32'(rd_valid), 0);
    chk("flush_ovf", 32'(overflow), 0);
    chk("flush_udf", 32'(underflow), 0);
    repeat (3) tick();
    wr_valid = 1; wr_data = 8'h3C;
    tick();
    wr_valid = 0;
    for (int c = 0; c < 5 && !rd_valid; c++) tick();
    chk("flush_first_valid", 32'(rd_valid), 1);
    chk("flush_first_word", 32'(rd_data), 32'h3C);
    rd_ready = 1;
    tick();
    rd_ready = 0;

    // Asynchronous reset between edges with 5 words queued
    for (int c = 0; c < 5; c++) begin
      wr_valid = 1;
      wr_data = 8'(8'h60 + c);
      tick();
    end
    wr_valid = 0;
    tick();
    #3;
    rst_n = 0;
    q.delete();
    m_ovf = 0;
    m_udf = 0;
    #1;
    check_reset_outputs("arst");
    @(posedge clk);
    #1;
    rst_n = 1;
    tick();
    chk("arst_wr_ready", 32'(wr_ready), 1);
    wr_valid = 1; wr_data = 8'h77;
    tick();
    wr_valid = 0;
    chk("arst_rd_valid_e0", 32'(rd_valid), 0);
    tick();
    chk("arst_rd_valid_e1", 32'(rd_valid), 0);
    tick();
    chk("arst_rd_valid_e2", 32'(rd_valid), 1);
    chk("arst_rd_data_e2", 32'(rd_data), 32'h77);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
